p_i_line_fill_adapter: RTL and testbench

- Sits directly downstream of the pipelined I-cache control, on its physical-memory side.
- Accepts a one-line fill request (pmem_read / address) from the I-cache and issues a read burst of NUM_BEATS beats to the memory / arbiter port.
- Assembles the beats into one cache line and returns it with a single-cycle line_resp pulse, which the I-cache treats as pmem_resp.
- Read-only: instruction side, no writeback path.

---
 rtl/p_i_line_fill_adapter_pkg.sv | 29 ++
 rtl/p_i_line_fill_adapter_if.sv | 24 ++
 rtl/p_i_line_fill_adapter_assembler.sv | 38 +++
 rtl/p_i_line_fill_adapter.sv | 191 +++++++++++++++++++
 tb/tb_p_i_line_fill_adapter.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/p_i_line_fill_adapter_pkg.sv
// Shared types and geometry for the instruction-side line fill adapter.
package i_line_adapter_types;

  localparam int BEAT_WIDTH = 64;
  localparam int NUM_BEATS  = 4;
  localparam int ADDR_WIDTH = 32;

  localparam int LINE_WIDTH = BEAT_WIDTH * NUM_BEATS;
  localparam int LINE_BYTES = LINE_WIDTH / 8;
  localparam int OFFSET     = $clog2(LINE_BYTES);
  localparam int BEAT_IDX_W = $clog2(NUM_BEATS);

  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~(ADDR_WIDTH'(LINE_BYTES) - 1'b1);

  typedef logic [ADDR_WIDTH-1:OFFSET] line_addr_t;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    RESP,
    PF_BURST
  } state_t;

  // Address of the line following addr; wraps modulo 2^ADDR_WIDTH.
  function automatic logic [ADDR_WIDTH-1:0] next_line(input logic [ADDR_WIDTH-1:0] addr);
    return addr + ADDR_WIDTH'(LINE_BYTES);
  endfunction

endpackage

// File: rtl/p_i_line_fill_adapter_if.sv
// Line request port (I-cache side) and burst read port (memory side).
interface i_line_if;
  import i_line_adapter_types::*;

  logic                  line_read;
  logic [ADDR_WIDTH-1:0] line_addr;
  logic                  line_resp;
  logic [LINE_WIDTH-1:0] line_rdata;

  modport master (output line_read, line_addr, input line_resp, line_rdata);
  modport slave  (input line_read, line_addr, output line_resp, line_rdata);
endinterface

interface i_burst_if;
  import i_line_adapter_types::*;

  logic                  burst_read;
  logic [ADDR_WIDTH-1:0] burst_addr;
  logic                  burst_resp;
  logic [BEAT_WIDTH-1:0] burst_rdata;

  modport master (output burst_read, burst_addr, input burst_resp, burst_rdata);
  modport slave  (input burst_read, burst_addr, output burst_resp, burst_rdata);
endinterface

// File: rtl/p_i_line_fill_adapter_assembler.sv
// Beat counter plus line register: each valid beat lands in the slot the counter points at.
module p_i_line_assembler
  import i_line_adapter_types::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  beat_valid,
  input  logic [BEAT_WIDTH-1:0] beat_data,
  output logic [LINE_WIDTH-1:0] line,
  output logic                  last_beat
);

  logic [BEAT_IDX_W-1:0] count;
  logic [BEAT_WIDTH-1:0] slot [NUM_BEATS];

  assign last_beat = beat_valid && (count == BEAT_IDX_W'(NUM_BEATS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             count <= '0;
    else if (clr)        count <= '0;
    else if (beat_valid) count <= count + 1'b1;
  end

  // NOTE: this storage is a flop bank, not a RAM, so it is reset; the returned line reads zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_BEATS; k++) slot[k] <= '0;
    end else if (beat_valid) begin
      slot[count] <= beat_data;
    end
  end

  for (genvar k = 0; k < NUM_BEATS; k++) begin : g_pack
    assign line[k*BEAT_WIDTH +: BEAT_WIDTH] = slot[k];
  end

endmodule

// File: rtl/p_i_line_fill_adapter.sv
// I-cache line fill adapter: one line request becomes a NUM_BEATS read burst.
// Define I_LINE_PREFETCH_EN to add a one-line next-line prefetch buffer.
module p_i_line_fill_adapter
  import i_line_adapter_types::*;
(
  input  logic      clk,
  input  logic      rst,
  i_line_if.slave   line,
  i_burst_if.master burst
);

  state_t                state_q, state_d;
  logic                  line_resp_q, line_resp_d;
  logic                  burst_read_q, burst_read_d;
  logic [ADDR_WIDTH-1:0] burst_addr_q, burst_addr_d;
  logic                  abort_q, abort_d;
  logic                  start_demand;
  logic [ADDR_WIDTH-1:0] req_addr;

  logic                  dem_clr, dem_valid, dem_last;
  logic [LINE_WIDTH-1:0] dem_line;

  assign req_addr  = line.line_addr & LINE_MASK;
  assign dem_valid = burst.burst_resp && (state_q == BURST);

  p_i_line_assembler u_dem (
    .clk       (clk),
    .rst       (rst),
    .clr       (dem_clr),
    .beat_valid(dem_valid),
    .beat_data (burst.burst_rdata),
    .line      (dem_line),
    .last_beat (dem_last)
  );

`ifdef I_LINE_PREFETCH_EN
  line_addr_t            req_tag, pf_tag_q, pf_tag_d;
  logic                  pf_valid_q, pf_valid_d;
  logic                  pf_pend_q, pf_pend_d;
  logic                  src_pf_q, src_pf_d;
  logic                  pf_clr, pf_valid_beat, pf_last;
  logic [LINE_WIDTH-1:0] pf_line;

  assign req_tag       = req_addr[ADDR_WIDTH-1:OFFSET];
  assign pf_valid_beat = burst.burst_resp && (state_q == PF_BURST);

  p_i_line_assembler u_pf (
    .clk       (clk),
    .rst       (rst),
    .clr       (pf_clr),
    .beat_valid(pf_valid_beat),
    .beat_data (burst.burst_rdata),
    .line      (pf_line),
    .last_beat (pf_last)
  );

  assign line.line_rdata = src_pf_q ? pf_line : dem_line;
`else
  assign line.line_rdata = dem_line;
`endif

  assign line.line_resp   = line_resp_q;
  assign burst.burst_read = burst_read_q;
  assign burst.burst_addr = burst_addr_q;

  always_comb begin
    // NOTE: every target gets a default first so no path through the case can infer a latch.
    state_d      = state_q;
    line_resp_d  = 1'b0;
    burst_read_d = burst_read_q;
    burst_addr_d = burst_addr_q;
    abort_d      = abort_q;
    dem_clr      = 1'b0;
    start_demand = 1'b0;
`ifdef I_LINE_PREFETCH_EN
    pf_valid_d   = pf_valid_q;
    pf_tag_d     = pf_tag_q;
    pf_pend_d    = pf_pend_q;
    src_pf_d     = src_pf_q;
    pf_clr       = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
`ifdef I_LINE_PREFETCH_EN
        if (line.line_read) begin
          pf_pend_d = 1'b0;
          if (pf_valid_q && (pf_tag_q == req_tag)) begin
            state_d      = RESP;
            line_resp_d  = 1'b1;
            pf_valid_d   = 1'b0;
            src_pf_d     = 1'b1;
            burst_addr_d = req_addr;
          end else begin
            start_demand = 1'b1;
          end
        end else if (pf_pend_q) begin
          state_d      = PF_BURST;
          burst_addr_d = next_line(burst_addr_q);
          burst_read_d = 1'b1;
          pf_clr       = 1'b1;
          pf_valid_d   = 1'b0;
          pf_pend_d    = 1'b0;
        end
`else
        start_demand = line.line_read;
`endif
      end

      BURST: begin
        // Memory cannot abandon a burst, so a dropped request only suppresses the response.
        if (!line.line_read) abort_d = 1'b1;
        if (dem_last) begin
          burst_read_d = 1'b0;
          if (abort_q || !line.line_read) begin
            state_d = IDLE;
          end else begin
            state_d     = RESP;
            line_resp_d = 1'b1;
          end
        end
      end

      RESP: begin
        state_d = IDLE;
`ifdef I_LINE_PREFETCH_EN
        pf_pend_d = 1'b1;
`endif
      end

`ifdef I_LINE_PREFETCH_EN
      PF_BURST: begin
        if (pf_last) begin
          burst_read_d = 1'b0;
          state_d      = IDLE;
          if (line.line_read && (burst_addr_q[ADDR_WIDTH-1:OFFSET] == req_tag)) begin
            state_d     = RESP;
            line_resp_d = 1'b1;
            src_pf_d    = 1'b1;
          end else if (!line.line_read) begin
            pf_valid_d = 1'b1;
            pf_tag_d   = burst_addr_q[ADDR_WIDTH-1:OFFSET];
          end
        end
      end
`endif

      default: state_d = IDLE;
    endcase

    if (start_demand) begin
      state_d      = BURST;
      burst_addr_d = req_addr;
      burst_read_d = 1'b1;
      abort_d      = 1'b0;
      dem_clr      = 1'b1;
`ifdef I_LINE_PREFETCH_EN
      src_pf_d     = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      line_resp_q  <= 1'b0;
      burst_read_q <= 1'b0;
      burst_addr_q <= '0;
      abort_q      <= 1'b0;
`ifdef I_LINE_PREFETCH_EN
      pf_valid_q   <= 1'b0;
      pf_tag_q     <= '0;
      pf_pend_q    <= 1'b0;
      src_pf_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      line_resp_q  <= line_resp_d;
      burst_read_q <= burst_read_d;
      burst_addr_q <= burst_addr_d;
      abort_q      <= abort_d;
`ifdef I_LINE_PREFETCH_EN
      pf_valid_q   <= pf_valid_d;
      pf_tag_q     <= pf_tag_d;
      pf_pend_q    <= pf_pend_d;
      src_pf_q     <= src_pf_d;
`endif
    end
  end

endmodule

// File: tb/tb_p_i_line_fill_adapter.sv
// Directed bench for the line fill adapter (default build, no prefetch).
module tb_p_i_line_fill_adapter;
  import i_line_adapter_types::*;

  logic clk = 1'b0;
  logic rst;

  i_line_if  lbus ();
  i_burst_if bbus ();

  p_i_line_fill_adapter dut (
    .clk  (clk),
    .rst  (rst),
    .line (lbus.slave),
    .burst(bbus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [LINE_WIDTH-1:0] last_line;

  task automatic check(input string tag, input logic [LINE_WIDTH-1:0] obs,
                       input logic [LINE_WIDTH-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [BEAT_WIDTH-1:0] pat(input int n);
    logic [3:0] nib;
    nib = n[3:0];
    return {16{nib}};
  endfunction

  // One fill, called at a falling edge. gap_at: beat preceded by gap_len idle cycles;
  // drop_at: line_read falls after this beat; move_at: line_addr moves before this beat.
  task automatic do_fill(input string tag, input logic [31:0] addr, input int first_nib,
                         input int gap_at, input int gap_len, input int drop_at,
                         input int move_at, input bit want_resp);
    logic [LINE_WIDTH-1:0] exp_line;
    logic [31:0]           exp_addr;
    exp_line = '0;
    exp_addr = addr & 32'hFFFF_FFE0;
    lbus.line_read = 1'b1;
    lbus.line_addr = addr;
    @(negedge clk);
    check({tag, " accept burst_read"}, LINE_WIDTH'(bbus.burst_read), LINE_WIDTH'(1'b1));
    check({tag, " burst_addr"}, LINE_WIDTH'(bbus.burst_addr), LINE_WIDTH'(exp_addr));
    for (int k = 0; k < NUM_BEATS; k++) begin
      if (k == gap_at) begin
        repeat (gap_len) begin
          bbus.burst_resp = 1'b0;
          @(negedge clk);
          check({tag, " gap burst_read"}, LINE_WIDTH'(bbus.burst_read), LINE_WIDTH'(1'b1));
          check({tag, " gap line_resp"}, LINE_WIDTH'(lbus.line_resp), '0);
        end
      end
      if (drop_at >= 0 && k == drop_at + 1) lbus.line_read = 1'b0;
      if (k == move_at) lbus.line_addr = 32'h0000_0800;
      bbus.burst_resp  = 1'b1;
      bbus.burst_rdata = pat(first_nib + k);
      exp_line[k*BEAT_WIDTH +: BEAT_WIDTH] = pat(first_nib + k);
      @(negedge clk);
      if (k < NUM_BEATS - 1) begin
        check({tag, " beat line_resp"}, LINE_WIDTH'(lbus.line_resp), '0);
        check({tag, " beat burst_read"}, LINE_WIDTH'(bbus.burst_read), LINE_WIDTH'(1'b1));
        check({tag, " beat burst_addr"}, LINE_WIDTH'(bbus.burst_addr), LINE_WIDTH'(exp_addr));
      end else begin
        check({tag, " resp"}, LINE_WIDTH'(lbus.line_resp), LINE_WIDTH'(want_resp));
      end
    end
    bbus.burst_resp = 1'b0;
    check({tag, " burst_read end"}, LINE_WIDTH'(bbus.burst_read), '0);
    if (want_resp) check({tag, " line_rdata"}, lbus.line_rdata, exp_line);
    lbus.line_read = 1'b0;
    @(negedge clk);
    check({tag, " resp one cycle"}, LINE_WIDTH'(lbus.line_resp), '0);
    if (want_resp) check({tag, " line_rdata held"}, lbus.line_rdata, exp_line);
    last_line = exp_line;
  endtask

  initial begin
    rst              = 1'b1;
    lbus.line_read   = 1'b0;
    lbus.line_addr   = '0;
    bbus.burst_resp  = 1'b0;
    bbus.burst_rdata = '0;
    last_line        = '0;
    repeat (2) @(negedge clk);
    check("reset line_resp", LINE_WIDTH'(lbus.line_resp), '0);
    check("reset burst_read", LINE_WIDTH'(bbus.burst_read), '0);
    check("reset burst_addr", LINE_WIDTH'(bbus.burst_addr), '0);
    check("reset line_rdata", lbus.line_rdata, '0);
    rst = 1'b0;
    @(negedge clk);

    do_fill("basic", 32'h0000_0064, 1, -1, 0, -1, -1, 1'b1);
    do_fill("gap", 32'h0000_0064, 1, 2, 2, -1, -1, 1'b1);
    do_fill("move", 32'h0000_0064, 1, -1, 0, -1, 2, 1'b1);
    do_fill("drop", 32'h0000_0064, 1, -1, 0, 1, -1, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("drop idle line_resp", LINE_WIDTH'(lbus.line_resp), '0);
      check("idle burst_read", LINE_WIDTH'(bbus.burst_read), '0);
    end
    do_fill("refill", 32'h0000_0100, 5, -1, 0, -1, -1, 1'b1);

    // A stray beat in IDLE must neither land in the line nor advance the counter.
    bbus.burst_resp  = 1'b1;
    bbus.burst_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    @(negedge clk);
    bbus.burst_resp = 1'b0;
    check("stray line_rdata", lbus.line_rdata, last_line);
    check("stray line_resp", LINE_WIDTH'(lbus.line_resp), '0);
    do_fill("after stray", 32'h0000_001F, 10, -1, 0, -1, -1, 1'b1);

    // Reset after three beats: outputs fall without a clock edge.
    lbus.line_read = 1'b1;
    lbus.line_addr = 32'h0000_0300;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      bbus.burst_resp  = 1'b1;
      bbus.burst_rdata = pat(k + 1);
      @(negedge clk);
    end
    check("pre-rst burst_read", LINE_WIDTH'(bbus.burst_read), LINE_WIDTH'(1'b1));
    #2 rst = 1'b1;
    #1;
    check("async rst burst_read", LINE_WIDTH'(bbus.burst_read), '0);
    check("async rst line_resp", LINE_WIDTH'(lbus.line_resp), '0);
    check("async rst burst_addr", LINE_WIDTH'(bbus.burst_addr), '0);
    check("async rst line_rdata", lbus.line_rdata, '0);
    bbus.burst_resp = 1'b0;
    lbus.line_read  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_fill("post rst", 32'h0000_0200, 6, -1, 0, -1, -1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
